// File: rtl/alu_pkg.sv
// Shared ALU control encodings, datapath width and arbiter slot-state type.
// Latency: none, declarations only.
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_ctrl_e;

    // Result slot occupancy
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own accept condition.
//
// Ports:
//   valid [NREQ]  candidate requests
//   ptr   [IDW]   highest-priority index this cycle (must be < NREQ)
//   grant [NREQ]  one-hot winner, zero when nothing is valid
//   idx   [IDW]   binary index of the winner, 0 when nothing is valid
//   any           at least one candidate was valid
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Walk offsets 0..NREQ-1 from the pointer; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && valid[IDW'(cand)]) begin
                any                = 1'b1;
                grant[IDW'(cand)]  = 1'b1;
                idx                = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// Latency: request accepted in cycle N gives rsp_valid in N+1; 1 op/cycle sustained.
// Backpressure: full slot with rsp_ready low stalls all req_ready; drain+fill same cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready [NREQ]    per-requester handshake (ready is one-hot or zero)
//   req_a/req_b [NREQ*32]         operands, requester i at [32i+31:32i]
//   req_ctrl [NREQ*4]             ALU control code, same packing
//   alu_a/alu_b/alu_ctrl          drive the shared ALU
//   alu_o                         ALU result, sampled into the slot on accept
//   rsp_valid/rsp_ready           result slot handshake
//   rsp_data, rsp_id              registered result and the requester that produced it
//   grant_cnt [NREQ*16]           only with ALU_SHARE_ARB_PERF_EN: saturating per-requester
//                                 accepted-request counters
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_ctrl,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    output logic [3:0]            alu_ctrl,
    input  logic [ALU_W-1:0]      alu_o,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ALU_W-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt
`endif
);

    arb_state_e       state_q, state_d;
    logic [ALU_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [IDW-1:0]   sel;
    logic             can_accept;
    logic             fire;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The slot can take a new result when empty, or when the held one
    // leaves this same cycle.
    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign fire       = can_accept && pick_any && !rst;
    assign req_ready  = fire ? pick_grant : '0;

    // Operands come from the picked requester, or requester 0 when idle, so
    // the ALU inputs are always defined values.
    assign sel = pick_any ? pick_idx : '0;

    always_comb begin
        alu_a    = req_a[ALU_W-1:0];
        alu_b    = req_b[ALU_W-1:0];
        alu_ctrl = req_ctrl[3:0];
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                alu_a    = req_a[i*ALU_W +: ALU_W];
                alu_b    = req_b[i*ALU_W +: ALU_W];
                alu_ctrl = req_ctrl[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        ptr_d      = ptr_q;
        if (fire) begin
            state_d    = FULL;
            rsp_data_d = alu_o;
            rsp_id_d   = pick_idx;
            ptr_d      = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end else if ((state_q == FULL) && rsp_ready) begin
            // Drained with nothing to refill; data stays as the last result.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            // Counters stick at all-ones rather than wrapping.
            if (fire && (pick_idx == IDW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
        assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: scoreboard of expected responses fed by a request-level model.
// Latency: checks responses one cycle after acceptance via the queue order.
// Backpressure: drives random rsp_ready stalls and request withdrawals.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    typedef struct packed {
        logic [31:0]    d;
        logic [IDW-1:0] id;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_ctrl;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [3:0]           alu_ctrl;
    logic [31:0]          alu_o;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [NREQ*16-1:0]   grant_cnt;
`endif

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_o     (alu_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU; also serves as the external ALU instance.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return (a < b) ? 32'd1 : 32'd0;
            4'b0110: return a ^ b;
            4'b1000: return a << b[4:0];
            4'b1010: return a >> b[4:0];
            4'b1011: return $signed(a) >>> b[4:0];
            4'b1100: return a | b;
            4'b1110: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_o = alu_f(alu_a, alu_b, alu_ctrl);

    // Request-level state of the bench
    bit              pend [NREQ];
    logic [31:0]     op_a [NREQ];
    logic [31:0]     op_b [NREQ];
    logic [3:0]      op_c [NREQ];
    logic            rdy_drv;
    int              m_ptr;
    bit              m_full;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_vld;
    exp_t            q [$];
    int              rsp_cnt [NREQ];
    bit              mon_en;
    int              n_vec;
    int              n_err;
    logic [3:0]      codes [12] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1000,
                                    4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b0000, 4'b0001};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive the current request set and predict this cycle's outcome.
    task automatic apply();
        int g;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_a[i*32 +: 32]   = op_a[i];
            req_b[i*32 +: 32]   = op_b[i];
            req_ctrl[i*4 +: 4]  = op_c[i];
        end
        rsp_ready = rdy_drv;
        exp_vld   = m_full;
        exp_rdy   = '0;
        g         = -1;
        if (!m_full || rdy_drv) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            q.push_back('{d: alu_f(op_a[g], op_b[g], op_c[g]), id: IDW'(g)});
            pend[g] = 1'b0;
            m_ptr   = (g + 1) % NREQ;
            m_full  = 1'b1;
        end else if (rdy_drv) begin
            m_full = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic set_op(input int i, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        pend[i] = 1'b1;
        op_c[i] = c;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic clear_model();
        q.delete();
        m_full  = 1'b0;
        m_ptr   = 0;
        exp_rdy = '0;
        exp_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        req_valid = '1;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        clear_model();
        req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compares handshake and pops the scoreboard on every response taken.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_extra: got id %0d data %h expected no response", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e.d));
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                end
                rsp_cnt[int'(rsp_id)]++;
            end
        end
    end

    initial begin
        logic [31:0]    d0;
        logic [IDW-1:0] i0;
        int             c0 [NREQ];
        n_vec = 0;
        n_err = 0;
        mon_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; rsp_cnt[i] = 0;
        end
        clear_model();
        rdy_drv   = 1'b1;
        rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_ctrl = '0;
        req_valid = '1;
        rst = 1'b1;
        #2;
        chk("init_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("init_rsp_data", 64'(rsp_data), 64'd0);
        chk("init_rsp_id", 64'(rsp_id), 64'd0);
        chk("init_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single op
        set_op(0, 4'b0010, 32'd5, 32'd7);
        cycle();
        #1;
        chk("single_ready", 64'(req_ready), 64'b01);
        cycle();
        @(negedge clk);
        chk("single_vld", 64'(rsp_valid), 64'd1);
        chk("single_data", 64'(rsp_data), 64'd12);
        chk("single_id", 64'(rsp_id), 64'd0);

        // Contention from a fresh pointer
        cycle();
        do_reset();
        set_op(0, 4'b0011, 32'd3, 32'd5);
        set_op(1, 4'b0101, 32'hFFFF_FFFF, 32'd1);
        cycle();
        cycle();
        @(negedge clk);
        chk("cont_data0", 64'(rsp_data), 64'hFFFF_FFFE);
        chk("cont_id0", 64'(rsp_id), 64'd0);
        cycle();
        @(negedge clk);
        chk("cont_data1", 64'(rsp_data), 64'd0);
        chk("cont_id1", 64'(rsp_id), 64'd1);

        // Fairness: both held valid for 8 accepts
        for (int i = 0; i < NREQ; i++) c0[i] = rsp_cnt[i];
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) set_op(i, codes[$urandom_range(0, 9)], $urandom, $urandom);
            end
            cycle();
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        cycle();
        @(negedge clk);
        chk("fair_cnt0", 64'(rsp_cnt[0] - c0[0]), 64'd4);
        chk("fair_cnt1", 64'(rsp_cnt[1] - c0[1]), 64'd4);

        // Backpressure
        rdy_drv = 1'b0;
        set_op(0, 4'b0110, 32'h0000_F0F0, 32'h0000_0FF0);
        cycle();
        set_op(1, 4'b1011, 32'h8000_0000, 32'd4);
        cycle();
        @(negedge clk);
        d0 = rsp_data;
        i0 = rsp_id;
        chk("bp_data0", 64'(d0), 64'h0000_FF00);
        chk("bp_id0", 64'(i0), 64'd0);
        for (int n = 0; n < 2; n++) begin
            cycle();
            @(negedge clk);
            chk("bp_ready_stall", 64'(req_ready), 64'd0);
            chk("bp_data_hold", 64'(rsp_data), 64'(d0));
            chk("bp_id_hold", 64'(rsp_id), 64'(i0));
        end
        rdy_drv = 1'b1;
        cycle();
        #1;
        chk("bp_refill_ready", 64'(req_ready), 64'b10);
        cycle();
        @(negedge clk);
        chk("bp_sra_vld", 64'(rsp_valid), 64'd1);
        chk("bp_sra_data", 64'(rsp_data), 64'hF800_0000);
        chk("bp_sra_id", 64'(rsp_id), 64'd1);

        // Reset with a result pending
        rdy_drv = 1'b0;
        set_op(0, 4'b1100, 32'h1234_0000, 32'h0000_5678);
        cycle();
        cycle();
        do_reset();
        rdy_drv = 1'b1;
        set_op(0, 4'b0010, 32'd1, 32'd2);
        set_op(1, 4'b0010, 32'd3, 32'd4);
        cycle();
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'b01);

        // Randomized traffic with stalls and withdrawals
        for (int n = 0; n < 400; n++) begin
            rdy_drv = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) set_op(i, codes[$urandom_range(0, 11)], $urandom, $urandom);
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            cycle();
        end
        rdy_drv = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

`ifdef ALU_SHARE_ARB_PERF_EN
        begin
            logic [31:0] exp_cnt;
            cycle();
            do_reset();
            for (int n = 0; n < 5; n++) begin
                set_op(0, 4'b0010, $urandom, $urandom);
                cycle();
            end
            for (int n = 0; n < 3; n++) begin
                set_op(1, 4'b0011, $urandom, $urandom);
                cycle();
            end
            cycle();
            #1;
            exp_cnt = {16'd3, 16'd5};
            chk("perf_grant_cnt", 64'(grant_cnt), 64'(exp_cnt));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
